// File: rtl/mac_pkg.sv
// Shared Ethernet framing constants, framer state encoding and header helper.
package mac_pkg;

    localparam int unsigned ETH_HDR_LEN     = 14;
    localparam int unsigned ETH_MIN_PAYLOAD = 46;
    localparam int unsigned ETH_MAX_PAYLOAD = 1500;

    // Framer states, kept as plain constants for compatibility with older tools.
    typedef logic [2:0] framer_state_t;
    localparam framer_state_t StIdle    = 3'd0;
    localparam framer_state_t StHdr     = 3'd1;
    localparam framer_state_t StPayload = 3'd2;
    localparam framer_state_t StPad     = 3'd3;
    localparam framer_state_t StDrop    = 3'd4;
    localparam framer_state_t StGap     = 3'd5;

    // Header in wire order: byte 0 sits in [111:104].
    function automatic logic [111:0] eth_hdr_cat(input logic [47:0] dst,
                                                 input logic [47:0] src,
                                                 input logic [15:0] ethertype);
        return {dst, src, ethertype};
    endfunction

endpackage

// File: rtl/mac_tx_framer.sv
// Ethernet frame source for the MAC transmit interface: header insertion,
// minimum-size padding, truncation and post-frame gap enforcement.
module mac_tx_framer
    import mac_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = ETH_MAX_PAYLOAD,
    parameter int unsigned IFG_CYCLES  = 26
) (
    input  logic        mac_tx_clk,
    input  logic        rst_n,
    input  logic [47:0] cfg_dst_mac,
    input  logic [47:0] cfg_src_mac,
    input  logic [15:0] cfg_ethertype,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_valid,
    output logic        mac_tx_sof,
    output logic        mac_tx_eof,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        trunc_o,
    output logic        underrun_o
);

    localparam int unsigned GapW = $clog2(IFG_CYCLES + 1);
    localparam logic [GapW-1:0] GapInit = GapW'(IFG_CYCLES);
    localparam logic [10:0] MinPay  = 11'(ETH_MIN_PAYLOAD);
    localparam logic [10:0] MaxPay  = 11'(MAX_PAYLOAD);
    localparam logic [3:0]  HdrLast = 4'(ETH_HDR_LEN - 1);

    framer_state_t   state_q, state_d;
    logic [111:0]    hdr_q, hdr_d;
    logic [3:0]      hdr_idx_q, hdr_idx_d;
    logic [10:0]     pay_cnt_q, pay_cnt_d;
    logic [10:0]     cnt_next;
    logic [GapW-1:0] gap_q, gap_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            sof_q, sof_d;
    logic            eof_q, eof_d;
    logic            done_q, done_d;
    logic            trunc_q, trunc_d;
    logic            under_q, under_d;
    logic [7:0]      hdr_byte;

    assign cnt_next = pay_cnt_q + 11'd1;

    // 14:1 header byte select on hdr_idx.
    always_comb begin
        hdr_byte = 8'h00;
        for (int i = 0; i < int'(ETH_HDR_LEN); i++) begin
            if (hdr_idx_q == 4'(i)) hdr_byte = hdr_q[111 - 8*i -: 8];
        end
    end

    // Next-state and next-output decode; every output defaults to idle (data 0).
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        hdr_idx_d = hdr_idx_q;
        pay_cnt_d = pay_cnt_q;
        gap_d     = gap_q;
        data_d    = 8'h00;
        valid_d   = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        trunc_d   = 1'b0;
        under_d   = 1'b0;
        done_d    = eof_q;
        case (state_q)
            StIdle: begin
                // Start on source valid; the byte itself is not consumed yet.
                if (s_valid) begin
                    hdr_d     = eth_hdr_cat(cfg_dst_mac, cfg_src_mac, cfg_ethertype);
                    data_d    = cfg_dst_mac[47:40];
                    valid_d   = 1'b1;
                    sof_d     = 1'b1;
                    hdr_idx_d = 4'd1;
                    pay_cnt_d = 11'd0;
                    state_d   = StHdr;
                end
            end
            StHdr: begin
                data_d  = hdr_byte;
                valid_d = 1'b1;
                if (hdr_idx_q == HdrLast) state_d = StPayload;
                else                      hdr_idx_d = hdr_idx_q + 4'd1;
            end
            StPayload: begin
                valid_d = 1'b1;
                if (s_valid) begin
                    data_d    = s_data;
                    pay_cnt_d = cnt_next;
                    if (s_last) begin
                        if (cnt_next >= MinPay) begin
                            eof_d   = 1'b1;
                            gap_d   = GapInit;
                            state_d = StGap;
                        end else begin
                            state_d = StPad;
                        end
                    end else if (cnt_next == MaxPay) begin
                        eof_d   = 1'b1;
                        trunc_d = 1'b1;
                        state_d = StDrop;
                    end
                end else begin
                    // Source starved mid-frame: close it with a filler byte.
                    eof_d   = 1'b1;
                    under_d = 1'b1;
                    state_d = StDrop;
                end
            end
            StPad: begin
                valid_d   = 1'b1;
                pay_cnt_d = cnt_next;
                if (cnt_next == MinPay) begin
                    eof_d   = 1'b1;
                    gap_d   = GapInit;
                    state_d = StGap;
                end
            end
            StDrop: begin
                if (s_valid && s_last) begin
                    gap_d   = GapInit;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q <= GapW'(1)) state_d = StIdle;
                else                   gap_d   = gap_q - GapW'(1);
            end
            default: begin
                gap_d   = GapInit;
                state_d = StGap;
            end
        endcase
    end

    // State and registered outputs; reset parks in GAP so a MAC CRC flush can finish.
    always_ff @(posedge mac_tx_clk) begin
        if (!rst_n) begin
            state_q   <= StGap;
            gap_q     <= GapInit;
            hdr_q     <= '0;
            hdr_idx_q <= '0;
            pay_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            done_q    <= 1'b0;
            trunc_q   <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            hdr_q     <= hdr_d;
            hdr_idx_q <= hdr_idx_d;
            pay_cnt_q <= pay_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            done_q    <= done_d;
            trunc_q   <= trunc_d;
            under_q   <= under_d;
        end
    end

    assign s_ready      = (state_q == StPayload) || (state_q == StDrop);
    assign busy_o       = (state_q != StIdle);
    assign mac_tx_data  = data_q;
    assign mac_tx_valid = valid_q;
    assign mac_tx_sof   = sof_q;
    assign mac_tx_eof   = eof_q;
    assign frame_done_o = done_q;
    assign trunc_o      = trunc_q;
    assign underrun_o   = under_q;

endmodule
